// File: rtl/csr_uart.sv
// Console UART behind a single CSR address: TX bytes queue in a small FIFO and leave as 8N1 frames,
// RX frames land in a one-byte holding register that software polls and pops.
module csr_uart #(
    parameter logic [11:0] BASE_ADDR     = 12'hBC0,
    parameter int          BAUD_DIV      = 16,
    parameter int          TX_DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        tx
);

    // tx FSM  state   | meaning
    //         T_IDLE  | line high, waiting for a queued byte
    //         T_START | start bit (low)
    //         T_DATA  | eight data bits, LSB first
    //         T_STOP  | stop bit (high); may chain straight into the next start bit
    // rx FSM  R_IDLE  | waiting for a falling edge on the synchronised line
    //         R_START | half a bit in, confirming the start bit
    //         R_DATA  | sampling eight data bits at mid-bit
    //         R_STOP  | sampling the stop bit; a high stop bit commits the byte
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    localparam int          D         = 1 << TX_DEPTH_LOG2;
    localparam int          PW        = TX_DEPTH_LOG2 + 1;
    localparam logic [15:0] BIT_LOAD  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LOAD = 16'(BAUD_DIV / 2 - 1);

    logic [11:0]   q_addr;
    logic          sel;
    logic          pop;
    logic          rx_valid;
    logic          overrun;
    logic [7:0]    rx_byte;
    logic          tx_full;
    logic          fifo_empty;
    logic          enq;
    logic          deq;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [7:0]    fifo_mem [D];
    logic          unused_wdata;

    tx_state_t     tx_state, tx_state_nx;
    logic [15:0]   tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    rx_state_t     rx_state, rx_state_nx;
    logic          rx_m, rx_s, rx_prev;
    logic [15:0]   rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          frame_good;

    assign unused_wdata = ^wdata[31:8];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_addr <= '0;
            valid  <= 1'b0;
        end else begin
            q_addr <= addr;
            valid  <= read && (addr == BASE_ADDR);
        end
    end

    assign sel   = (q_addr == BASE_ADDR);
    assign rdata = valid ? {21'b0, overrun, tx_full, rx_valid, rx_byte} : 32'b0;
    assign pop   = valid && rx_valid;

    assign count      = wr_ptr - rd_ptr;
    assign tx_full    = (count == PW'(D));
    assign fifo_empty = (wr_ptr == rd_ptr);
    // A dequeue in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign enq        = (modify == 3'd1) && sel && (!tx_full || deq);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) fifo_mem[wr_ptr[TX_DEPTH_LOG2-1:0]] <= wdata[7:0];
    end

    always_comb begin
        tx_state_nx = tx_state;
        deq         = 1'b0;
        tx          = 1'b1;
        case (tx_state)
            T_IDLE: begin
                if (!fifo_empty) begin
                    deq         = 1'b1;
                    tx_state_nx = T_START;
                end
            end
            T_START: begin
                tx = 1'b0;
                if (tx_cnt == 16'd0) tx_state_nx = T_DATA;
            end
            T_DATA: begin
                tx = tx_shift[0];
                if (tx_cnt == 16'd0 && tx_bit == 3'd7) tx_state_nx = T_STOP;
            end
            T_STOP: begin
                if (tx_cnt == 16'd0) begin
                    if (!fifo_empty) begin
                        deq         = 1'b1;
                        tx_state_nx = T_START;
                    end else begin
                        tx_state_nx = T_IDLE;
                    end
                end
            end
            default: tx_state_nx = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nx;
            if (deq) begin
                tx_shift <= fifo_mem[rd_ptr[TX_DEPTH_LOG2-1:0]];
                tx_cnt   <= BIT_LOAD;
                tx_bit   <= '0;
            end else if (tx_state != T_IDLE) begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt <= BIT_LOAD;
                    if (tx_state == T_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        rx_state_nx = rx_state;
        frame_good  = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_prev && !rx_s) rx_state_nx = R_START;
            end
            R_START: begin
                if (rx_cnt == 16'd0) rx_state_nx = rx_s ? R_IDLE : R_DATA;
            end
            R_DATA: begin
                if (rx_cnt == 16'd0 && rx_bit == 3'd7) rx_state_nx = R_STOP;
            end
            R_STOP: begin
                if (rx_cnt == 16'd0) begin
                    rx_state_nx = R_IDLE;
                    frame_good  = rx_s;
                end
            end
            default: rx_state_nx = R_IDLE;
        endcase
    end

    // Idle keeps the half-bit count preloaded so the first tick lands mid start bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nx;
            if (rx_state == R_IDLE) begin
                rx_cnt <= HALF_LOAD;
                rx_bit <= '0;
            end else if (rx_cnt == 16'd0) begin
                rx_cnt <= BIT_LOAD;
                if (rx_state == R_DATA) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
            end else begin
                rx_cnt <= rx_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            rx_byte  <= '0;
        end else if (frame_good) begin
            rx_byte  <= rx_shift;
            rx_valid <= 1'b1;
            if (pop)           overrun <= 1'b0;
            else if (rx_valid) overrun <= 1'b1;
        end else if (pop) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule
